// File: rtl/blood_bar_renderer_pkg.sv
// Shared constants and state encoding for the health-bar overlay and its
// health state machine.
package blood_bar_renderer_pkg;

  localparam int unsigned SPRITE_W = 64;
  localparam int unsigned SPRITE_H = 64;
  localparam int unsigned COLOR_W  = 12;

  localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

  typedef enum logic [1:0] {
    StAlive = 2'd0,
    StHit   = 2'd1,
    StDead  = 2'd2
  } state_e;

endpackage

// File: rtl/blood_bar_renderer_health_fsm.sv
// Player health counter with ALIVE/HIT/DEAD state, post-damage flash timer and
// blink phase. shown_health is a per-frame snapshot so the bar never tears.
module blood_bar_renderer_health_fsm
  import blood_bar_renderer_pkg::*;
#(
  parameter int unsigned MAX_HEALTH   = 5,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned BLINK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_damage,
  input  logic       i_heal,
  input  logic       i_revive,
  output logic [3:0] o_health,
  output logic [3:0] o_shown_health,
  output logic       o_hidden,
  output logic       o_dead
);

  localparam logic [3:0]  MAX_H      = 4'(MAX_HEALTH);
  localparam logic [15:0] FLASH_INIT = 16'(FLASH_FRAMES);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_DIV - 1);

  state_e      r_state;
  logic [3:0]  r_health;
  logic [3:0]  r_shown;
  logic [15:0] r_flash_cnt;
  logic [7:0]  r_blink_cnt;
  logic        r_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StAlive;
      r_health    <= MAX_H;
      r_shown     <= MAX_H;
      r_flash_cnt <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      // Snapshot uses the pre-update health, even when damage lands this cycle.
      if (i_frame_tick) r_shown <= r_health;

      case (r_state)
        StAlive: begin
          if (i_damage && !i_heal) begin
            if (r_health > 4'd1) begin
              r_health    <= r_health - 4'd1;
              r_state     <= StHit;
              r_flash_cnt <= FLASH_INIT;
              r_blink_cnt <= '0;
              r_blink     <= 1'b0;
            end else begin
              r_health <= '0;
              r_state  <= StDead;
            end
          end else if (i_heal && !i_damage && (r_health < MAX_H)) begin
            r_health <= r_health + 4'd1;
          end
        end

        StHit: begin
          // Invulnerable: damage is dropped, healing still counts.
          if (i_heal && (r_health < MAX_H)) r_health <= r_health + 4'd1;
          if (i_frame_tick) begin
            if (r_flash_cnt <= 16'd1) begin
              r_state     <= StAlive;
              r_flash_cnt <= '0;
              r_blink_cnt <= '0;
              r_blink     <= 1'b0;
            end else begin
              r_flash_cnt <= r_flash_cnt - 16'd1;
              if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
              end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
              end
            end
          end
        end

        StDead: begin
          if (i_revive) begin
            r_health <= MAX_H;
            r_state  <= StAlive;
          end
        end

        default: r_state <= StAlive;
      endcase
    end
  end

  assign o_health       = r_health;
  assign o_shown_health = r_shown;
  assign o_hidden       = r_blink;
  assign o_dead         = (r_state == StDead);

endmodule

// File: rtl/blood_bar_renderer.sv
// Health bar overlay: maps scan position onto the blood-drop sprite ROM and
// draws one icon per shown health point, two clocks behind x/y.
module blood_bar_renderer
  import blood_bar_renderer_pkg::*;
#(
  parameter int unsigned MAX_HEALTH   = 5,
  parameter int unsigned ORIGIN_X     = 16,
  parameter int unsigned ORIGIN_Y     = 16,
  parameter int unsigned FLASH_FRAMES = 60,
  parameter int unsigned BLINK_DIV    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         i_x,
  input  logic [9:0]         i_y,
  input  logic               i_video_on,
  input  logic               i_frame_tick,
  input  logic               i_damage,
  input  logic               i_heal,
  input  logic               i_revive,
  output logic [5:0]         o_rom_row,
  output logic [5:0]         o_rom_col,
  input  logic [COLOR_W-1:0] i_rom_data,
  output logic [COLOR_W-1:0] o_rgb_out,
  output logic               o_pixel_on,
  output logic [3:0]         o_health,
  output logic               o_dead
);

  localparam int unsigned X_END = ORIGIN_X + SPRITE_W * MAX_HEALTH;
  localparam int unsigned Y_END = ORIGIN_Y + SPRITE_H;

  logic [9:0]         w_dx;
  logic [3:0]         w_icon;
  logic               w_in_box;
  logic               w_icon_vis;
  logic               w_opaque;
  logic [3:0]         w_shown;
  logic               w_hidden;
  logic               w_dead;

  logic               r_s1_in_box;
  logic               r_s1_icon_vis;
  logic [COLOR_W-1:0] r_rgb;
  logic               r_pixel_on;

  blood_bar_renderer_health_fsm #(
    .MAX_HEALTH  (MAX_HEALTH),
    .FLASH_FRAMES(FLASH_FRAMES),
    .BLINK_DIV   (BLINK_DIV)
  ) u_health_fsm (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_tick  (i_frame_tick),
    .i_damage      (i_damage),
    .i_heal        (i_heal),
    .i_revive      (i_revive),
    .o_health      (o_health),
    .o_shown_health(w_shown),
    .o_hidden      (w_hidden),
    .o_dead        (w_dead)
  );

  assign w_dx      = i_x - 10'(ORIGIN_X);
  assign w_icon    = w_dx[9:6];
  assign o_rom_col = w_dx[5:0];
  assign o_rom_row = i_y[5:0] - 6'(ORIGIN_Y);

  // 11-bit compares so ORIGIN + bar width cannot wrap.
  assign w_in_box = i_video_on
                    && ({1'b0, i_x} >= 11'(ORIGIN_X)) && ({1'b0, i_x} < 11'(X_END))
                    && ({1'b0, i_y} >= 11'(ORIGIN_Y)) && ({1'b0, i_y} < 11'(Y_END));

  assign w_icon_vis = (w_icon < w_shown) && !w_hidden && !w_dead;

  assign w_opaque = r_s1_in_box && r_s1_icon_vis && (i_rom_data != TRANSPARENT);

  // Stage 1 runs alongside the ROM address register; stage 2 is the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_in_box   <= 1'b0;
      r_s1_icon_vis <= 1'b0;
      r_rgb         <= '0;
      r_pixel_on    <= 1'b0;
    end else begin
      r_s1_in_box   <= w_in_box;
      r_s1_icon_vis <= w_icon_vis;
      r_pixel_on    <= w_opaque;
      r_rgb         <= w_opaque ? i_rom_data : '0;
    end
  end

  assign o_rgb_out  = r_rgb;
  assign o_pixel_on = r_pixel_on;
  assign o_dead     = w_dead;

endmodule

// File: tb/tb_blood_bar_renderer.sv
// Directed bench for blood_bar_renderer: table of pixel vectors plus
// hand-written damage/blink/death/revive/reset sequences.
module tb_blood_bar_renderer;

  localparam int OX = 16;
  localparam int OY = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        video_on = 1'b0;
  logic        frame_tick = 1'b0;
  logic        damage = 1'b0;
  logic        heal = 1'b0;
  logic        revive = 1'b0;
  logic [5:0]  rom_row;
  logic [5:0]  rom_col;
  logic [11:0] rom_data = '0;
  logic [11:0] rgb_out;
  logic        pixel_on;
  logic [3:0]  health;
  logic        dead;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  blood_bar_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_x         (x),
    .i_y         (y),
    .i_video_on  (video_on),
    .i_frame_tick(frame_tick),
    .i_damage    (damage),
    .i_heal      (heal),
    .i_revive    (revive),
    .o_rom_row   (rom_row),
    .o_rom_col   (rom_col),
    .i_rom_data  (rom_data),
    .o_rgb_out   (rgb_out),
    .o_pixel_on  (pixel_on),
    .o_health    (health),
    .o_dead      (dead)
  );

  // Sprite ROM model: one red texel, one transparent texel, green elsewhere.
  function automatic logic [11:0] rom_fn(input logic [5:0] r, input logic [5:0] c);
    if (r == 6'd5 && c == 6'd7) return 12'hE00;
    if (r == 6'd5 && c == 6'd8) return 12'h000;
    return 12'h0F0;
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_row, rom_col);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pix(input int px, input int py, input logic vid);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    video_on = vid;
  endtask

  // Present a pixel and sample the output two clocks later.
  task automatic pix(input string name, input int px, input int py, input logic exp_on);
    set_pix(px, py, 1'b1);
    repeat (2) @(negedge clk);
    chk(name, 32'(pixel_on), 32'(exp_on));
  endtask

  task automatic pulse(input logic d, input logic h, input logic r, input logic t);
    @(negedge clk);
    damage = d;
    heal = h;
    revive = r;
    frame_tick = t;
    @(negedge clk);
    damage = 0;
    heal = 0;
    revive = 0;
    frame_tick = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    string      name;
    int         px;
    int         py;
    logic       vid;
    logic       exp_on;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"icon2_red",     OX + 128 + 7, OY + 5,  1'b1, 1'b1, 12'hE00};
    vecs[1] = '{"transparent",   OX + 128 + 8, OY + 5,  1'b1, 1'b0, 12'h000};
    vecs[2] = '{"left_edge",     OX - 1,       OY + 5,  1'b1, 1'b0, 12'h000};
    vecs[3] = '{"right_edge",    OX + 320,     OY + 5,  1'b1, 1'b0, 12'h000};
    vecs[4] = '{"last_col",      OX + 319,     OY + 5,  1'b1, 1'b1, 12'h0F0};
    vecs[5] = '{"first_px",      OX,           OY,      1'b1, 1'b1, 12'h0F0};
    vecs[6] = '{"bottom_edge",   OX + 135,     OY + 64, 1'b1, 1'b0, 12'h000};
    vecs[7] = '{"last_row",      OX + 135,     OY + 63, 1'b1, 1'b1, 12'h0F0};
    vecs[8] = '{"video_off",     OX + 135,     OY + 5,  1'b0, 1'b0, 12'h000};
    vecs[9] = '{"top_edge",      OX + 135,     OY - 1,  1'b1, 1'b0, 12'h000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    chk("rst_pix", 32'(pixel_on), 32'h0);
    chk("rst_health", 32'(health), 32'd5);
    chk("rst_dead", 32'(dead), 32'h0);
    rst_n = 1'b1;

    // Exact two-clock latency
    pix("lat_pre", 0, 0, 1'b0);
    set_pix(OX + 128 + 7, OY + 5, 1'b1);
    @(negedge clk);
    chk("lat_1clk", 32'(pixel_on), 32'h0);
    @(negedge clk);
    chk("lat_2clk", 32'(pixel_on), 32'h1);
    chk("lat_rgb", 32'(rgb_out), 32'hE00);

    for (int i = 0; i < 10; i++) begin
      set_pix(vecs[i].px, vecs[i].py, vecs[i].vid);
      repeat (2) @(negedge clk);
      chk({vecs[i].name, "_on"}, 32'(pixel_on), 32'(vecs[i].exp_on));
      chk({vecs[i].name, "_rgb"}, 32'(rgb_out), 32'(vecs[i].exp_rgb));
    end

    // Damage, HIT, snapshot timing and blink
    pix("icon4_before", OX + 256 + 7, OY + 5, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dmg_health", 32'(health), 32'd4);
    pix("icon4_until_tick", OX + 256 + 7, OY + 5, 1'b1);
    ticks(1);
    pix("icon4_gone", OX + 256 + 7, OY + 5, 1'b0);
    pix("icon3_hit", OX + 192 + 7, OY + 5, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dmg_in_hit", 32'(health), 32'd4);
    ticks(2);
    pix("blink_tick3", OX + 192 + 7, OY + 5, 1'b1);
    ticks(1);
    pix("blink_hidden", OX + 192 + 7, OY + 5, 1'b0);
    ticks(3);
    pix("blink_tick7", OX + 192 + 7, OY + 5, 1'b0);
    ticks(1);
    pix("blink_shown", OX + 192 + 7, OY + 5, 1'b1);
    ticks(51);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("invuln_tick59", 32'(health), 32'd4);
    ticks(1);

    // Back in ALIVE
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("dmg_heal_same", 32'(health), 32'd4);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("heal_to5", 32'(health), 32'd5);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("heal_sat", 32'(health), 32'd5);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("alive_after_60", 32'(health), 32'd4);

    // Walk down to death
    for (int h = 3; h >= 1; h--) begin
      ticks(60);
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      chk("walk_down", 32'(health), 32'(h));
    end
    ticks(60);
    pix("icon0_last", OX + 7, OY + 5, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("death_health", 32'(health), 32'd0);
    chk("death_flag", 32'(dead), 32'h1);
    pix("dead_no_pix", OX + 7, OY + 5, 1'b0);
    ticks(1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("dead_heal", 32'(health), 32'd0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("dead_dmg", 32'(health), 32'd0);
    pix("dead_icon4", OX + 256 + 7, OY + 5, 1'b0);

    // Revive
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("revive_health", 32'(health), 32'd5);
    chk("revive_dead", 32'(dead), 32'h0);
    pix("revive_pre_tick", OX + 7, OY + 5, 1'b0);
    ticks(1);
    pix("revive_icon0", OX + 7, OY + 5, 1'b1);
    pix("revive_icon4", OX + 256 + 7, OY + 5, 1'b1);

    // Asynchronous reset while in HIT
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("hit_again", 32'(health), 32'd4);
    pix("pre_rst_pix", OX + 7, OY + 5, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pix", 32'(pixel_on), 32'h0);
    chk("async_rst_rgb", 32'(rgb_out), 32'h0);
    chk("async_rst_health", 32'(health), 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("refill_pix", 32'(pixel_on), 32'h1);
    chk("refill_rgb", 32'(rgb_out), 32'hE00);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_to_alive", 32'(health), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blood_bar_renderer.md
Name: blood_bar_renderer

Overview:
Downstream consumer of the 64x64, 12-bit blood-drop sprite ROM. It converts the VGA scan position into ROM row/col addresses and draws a horizontal bar of MAX_HEALTH drop icons, one per remaining health point. It also owns the player's health counter and the hit/death state machine, including the blink animation after damage. Output feeds the top-level pixel mux as a transparent overlay.

Parameters:
MAX_HEALTH, 5, number of icons and maximum health value (1..15)
ORIGIN_X, 16, screen x of the left edge of icon 0
ORIGIN_Y, 16, screen y of the top edge of all icons
FLASH_FRAMES, 60, number of frames spent in HIT after damage
BLINK_DIV, 4, number of frames per blink half-period in HIT

Ports:
clk  in  1  pixel clock, shared with sprite ROM
rst_n  in  1  asynchronous active-low reset
x  in  10  current scan x
y  in  10  current scan y
video_on  in  1  active-video flag aligned with x/y
frame_tick  in  1  one-cycle pulse once per frame (start of vblank)
damage  in  1  one-cycle pulse: lose one health
heal  in  1  one-cycle pulse: gain one health
revive  in  1  one-cycle pulse: leave DEAD, health := MAX_HEALTH
rom_row  out  6  ROM row address (combinational from y)
rom_col  out  6  ROM col address (combinational from x)
rom_data  in  12  ROM colour, valid 1 clk after address
rgb_out  out  12  overlay colour
pixel_on  out  1  1 = overlay opaque at this pixel
health  out  4  current health
dead  out  1  1 while in DEAD

Behaviour:
- Reset values: health=MAX_HEALTH, shown_health=MAX_HEALTH, state=ALIVE, flash_cnt=0, blink=0, rgb_out=0, pixel_on=0, dead=0, pipeline valids=0.
- Address generation: dx=x-ORIGIN_X and dy=y-ORIGIN_Y, both 10-bit unsigned. in_box = video_on and x>=ORIGIN_X and x<ORIGIN_X+64*MAX_HEALTH and y>=ORIGIN_Y and y<ORIGIN_Y+64.
- Address outputs: rom_col=dx[5:0], rom_row=dy[5:0], icon=dx[9:6]. Outside in_box the address is don't-care.
- Pipeline: stage1 registers in_box and icon_vis=(icon<shown_health) and not hidden, alongside the ROM's internal address register. Stage2 registers the outputs.
- Latency: x/y presented before edge E gives rgb_out/pixel_on valid after edge E+1, i.e. 2 clocks.
- Transparency: rom_data==12'h000 means transparent.
- Output rule: pixel_on = s1_in_box and s1_icon_vis and rom_data!=0. rgb_out = rom_data when pixel_on, else 0.
- shown_health: updated from health only on frame_tick, so no tearing within a frame.
- Health arithmetic: saturating at 0 and MAX_HEALTH. damage and heal in the same cycle means no change.
- State ALIVE:
  - damage with health>1: health-1, go to HIT, flash_cnt=FLASH_FRAMES, blink=0.
  - damage with health==1: health=0, go to DEAD.
  - heal: health+1 (saturating).
- State HIT:
  - damage is ignored (invulnerable). heal is honoured.
  - Each frame_tick: flash_cnt-1. blink toggles every BLINK_DIV ticks. hidden=blink.
  - When flash_cnt reaches 0, go to ALIVE with blink=0.
- State DEAD:
  - dead=1. damage and heal ignored. The bar draws nothing.
  - revive: health=MAX_HEALTH, go to ALIVE, then shown_health updates at the next frame_tick.
- revive outside DEAD is ignored.
- frame_tick coinciding with damage: the state/health update and the frame_tick-driven update both apply in that cycle. shown_health latches the pre-damage health.
- Async reset mid-frame: outputs drop to 0 immediately. The pipeline refills within 2 clocks.

Decomposition:
- Shared package/header: SPRITE_W=64, SPRITE_H=64, COLOR_W=12, TRANSPARENT=12'h000, state encodings ALIVE/HIT/DEAD.
- Sub-module health_fsm: health counter, state, flash/blink counters. Outputs health, shown_health, hidden, dead.
- Top level: addressing, pipeline and colour muxing. The ROM is instantiated by the parent, not inside this block.

Test Plan:
- After reset, with a ROM model returning 12'hE00 at (row 5, col 7) and x=ORIGIN_X+64*2+7, y=ORIGIN_Y+5: rgb_out=12'hE00 and pixel_on=1 exactly 2 clks later. A pixel with rom_data=0 gives pixel_on=0.
- damage pulse at health=5: health=4 next clk, state HIT. Icon 4 is still drawn until the next frame_tick, then not drawn. The bar blinks every 4 frames, and after 60 frame_ticks returns to ALIVE.
- damage in HIT: health unchanged. damage and heal in the same cycle in ALIVE: health unchanged. heal at health=5: stays 5.
- Health 1 plus damage: health=0, dead=1, and no pixel_on anywhere. heal and damage have no effect. revive gives health=5, dead=0, and the bar shows 5 icons after the next frame_tick.
- Boundaries: x=ORIGIN_X-1, x=ORIGIN_X+64*MAX_HEALTH, and y=ORIGIN_Y+64 all give pixel_on=0. video_on=0 inside the box gives pixel_on=0.
- Assert rst_n=0 while in HIT mid-line: rgb_out=0 and pixel_on=0 asynchronously. After release, health=5 and state=ALIVE.
